// File: rtl/encoder_ctrl_pkg.sv
// encoder_ctrl_pkg
//   Shared types and constants for the 5x5 bit-array encoder controller.
//   - state_e      : controller FSM states (4-bit encoding)
//   - ctrl_t       : bundle of registered control outputs
//   - ctrl_decode  : per-state output decode (Moore), used for the output register
//   - START_IJ     : (i,j) start/stop coordinate of the index chain
//   - FIX_MAX      : most FIX cycles any element may need (-12 -> 3 in steps of +5)
package encoder_ctrl_pkg;

    localparam int unsigned START_IJ = 3;
    localparam int unsigned FIX_MAX  = 3;

    typedef enum logic [3:0] {
        StIdle = 4'd0,
        StInit = 4'd1,
        StRead = 4'd2,
        StCalc = 4'd3,
        StFix  = 4'd4,
        StUpd  = 4'd5,
        StWr   = 4'd6,
        StChk  = 4'd7,
        StFin  = 4'd8
    } state_e;

    typedef struct packed {
        logic ready;
        logic finish;
        logic init_line;
        logic ij_en;
        logic ij_reg_en;
        logic first_read;
        logic read;
        logic write_val;
        logic write_mem_reg;
        logic is_arith;
        logic ld_till_positive;
        logic wait_cal_next_i;
        logic update;
        logic write;
        logic ok;
        logic enable;
    } ctrl_t;

    // Outputs are a pure function of the state plus the first-read flag.
    function automatic ctrl_t ctrl_decode(state_e st, logic first);
        ctrl_t c;
        c        = '0;
        c.enable = (st != StIdle);
        case (st)
            StIdle: c.ready = 1'b1;
            StInit: begin
                c.init_line = 1'b1;
                c.ij_en     = 1'b1;
                c.ij_reg_en = 1'b1;
            end
            StRead: begin
                c.read          = 1'b1;
                c.write_val     = 1'b1;
                c.write_mem_reg = 1'b1;
                c.first_read    = first;
            end
            StCalc: begin
                c.is_arith         = 1'b1;
                c.ld_till_positive = 1'b1;
            end
            StFix: begin
                c.wait_cal_next_i  = 1'b1;
                c.ld_till_positive = 1'b1;
            end
            StUpd: begin
                c.update    = 1'b1;
                c.ij_reg_en = 1'b1;
            end
            StWr:  c.write = 1'b1;
            StFin: begin
                c.finish = 1'b1;
                c.ok     = 1'b1;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/encoder_controller_if.sv
// encoder_controller_if
//   Handshake and datapath-control bundle of the encoder controller.
//   master : controller side (drives ready/finish/controls/steps, samples start/done/sign)
//   slave  : top-level + datapath side
//   Optional macro ENCODER_CTRL_WDOG_EN adds the watchdog error flag err.
interface encoder_controller_if #(
    parameter int unsigned CNT_W = 5
) ();
    logic             start;
    logic             done;
    logic             sign;
    logic             ready;
    logic             finish;
    logic             initLine;
    logic             IJen;
    logic             IJregen;
    logic             firstread;
    logic             read;
    logic             writeVal;
    logic             writeMemReg;
    logic             isArith;
    logic             ldTillPositive;
    logic             waitCalNexti;
    logic             update;
    logic             write;
    logic             ok;
    logic             enable;
    logic             ALUop;
    logic             fbeq;
    logic             fb3j;
    logic [CNT_W-1:0] steps;
`ifdef ENCODER_CTRL_WDOG_EN
    logic             err;
`endif

    modport master (
`ifdef ENCODER_CTRL_WDOG_EN
        output err,
`endif
        input  start, done, sign,
        output ready, finish, initLine, IJen, IJregen, firstread, read, writeVal,
        output writeMemReg, isArith, ldTillPositive, waitCalNexti, update, write, ok,
        output enable, ALUop, fbeq, fb3j, steps
    );

    modport slave (
`ifdef ENCODER_CTRL_WDOG_EN
        input  err,
`endif
        output start, done, sign,
        input  ready, finish, initLine, IJen, IJregen, firstread, read, writeVal,
        input  writeMemReg, isArith, ldTillPositive, waitCalNexti, update, write, ok,
        input  enable, ALUop, fbeq, fb3j, steps
    );
endinterface

// File: rtl/step_counter.sv
// step_counter
//   Saturating move counter for the encoder controller.
//   clk_i, rst_ni : clock, asynchronous active-low reset (count -> 0)
//   clr_i         : synchronous clear (wins over inc_i)
//   inc_i         : increment by one, holds at all-ones
//   count_o       : current count
//   at_max_o      : count equals MaxSteps (watchdog compare)
module step_counter #(
    parameter int unsigned CntW     = 5,
    parameter int unsigned MaxSteps = 24
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            clr_i,
    input  logic            inc_i,
    output logic [CntW-1:0] count_o,
    output logic            at_max_o
);

    logic [CntW-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o  = count_q;
    assign at_max_o = (count_q == CntW'(MaxSteps));

endmodule

// File: rtl/encoder_controller.sv
// encoder_controller
//   Moore FSM sequencing the 5x5 bit-array encoder datapath through one
//   permutation pass: load line, then READ/CALC/FIX*/UPD/WR/CHK per element
//   until the datapath reports (i,j) back at (3,3).
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : encoder_controller_if.master (start/done/sign in, controls/steps out)
//   Optional macro ENCODER_CTRL_WDOG_EN: terminate a pass after MAX_STEPS moves
//   with bus.err=1 when done never arrives.
module encoder_controller
    import encoder_ctrl_pkg::*;
#(
    parameter int unsigned MAX_STEPS = 24,
    parameter int unsigned CNT_W     = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    encoder_controller_if.master bus
);

    state_e     state_q, state_d;
    logic       first_q, first_d;
    ctrl_t      ctrl_q, ctrl_d;
    logic       steps_clr, steps_inc;
    logic       wdog_hit;
    logic [CNT_W-1:0] steps;
`ifdef ENCODER_CTRL_WDOG_EN
    logic       err_q, err_d;
`else
    logic       unused_wdog;
    assign unused_wdog = wdog_hit;
`endif

    step_counter #(
        .CntW     (CNT_W),
        .MaxSteps (MAX_STEPS)
    ) u_step_counter (
        .clk_i    (clk),
        .rst_ni   (rst),
        .clr_i    (steps_clr),
        .inc_i    (steps_inc),
        .count_o  (steps),
        .at_max_o (wdog_hit)
    );

    always_comb begin
        state_d   = state_q;
        first_d   = first_q;
        steps_clr = 1'b0;
        steps_inc = 1'b0;
`ifdef ENCODER_CTRL_WDOG_EN
        err_d     = err_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d   = StInit;
                    first_d   = 1'b1;
                    steps_clr = 1'b1;
`ifdef ENCODER_CTRL_WDOG_EN
                    err_d     = 1'b0;
`endif
                end
            end
            StInit: state_d = StRead;
            StRead: begin
                state_d = StCalc;
                first_d = 1'b0;
            end
            StCalc: state_d = bus.sign ? StFix : StUpd;
            StFix:  state_d = bus.sign ? StFix : StUpd;
            StUpd:  state_d = StWr;
            StWr: begin
                state_d   = StChk;
                steps_inc = 1'b1;
            end
            // CHK is only reached after an UPD, so the initial (3,3) never ends a pass.
            StChk: begin
                if (bus.done) begin
                    state_d = StFin;
`ifdef ENCODER_CTRL_WDOG_EN
                end else if (wdog_hit) begin
                    state_d = StFin;
                    err_d   = 1'b1;
`endif
                end else begin
                    state_d = StRead;
                end
            end
            StFin:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
        // Decode from the next state so the registered outputs track state_q exactly.
        ctrl_d = ctrl_decode(state_d, first_d);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            first_q <= 1'b1;
            ctrl_q  <= ctrl_decode(StIdle, 1'b1);
`ifdef ENCODER_CTRL_WDOG_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            first_q <= first_d;
            ctrl_q  <= ctrl_d;
`ifdef ENCODER_CTRL_WDOG_EN
            err_q   <= err_d;
`endif
        end
    end

    assign bus.ready          = ctrl_q.ready;
    assign bus.finish         = ctrl_q.finish;
    assign bus.initLine       = ctrl_q.init_line;
    assign bus.IJen           = ctrl_q.ij_en;
    assign bus.IJregen        = ctrl_q.ij_reg_en;
    assign bus.firstread      = ctrl_q.first_read;
    assign bus.read           = ctrl_q.read;
    assign bus.writeVal       = ctrl_q.write_val;
    assign bus.writeMemReg    = ctrl_q.write_mem_reg;
    assign bus.isArith        = ctrl_q.is_arith;
    assign bus.ldTillPositive = ctrl_q.ld_till_positive;
    assign bus.waitCalNexti   = ctrl_q.wait_cal_next_i;
    assign bus.update         = ctrl_q.update;
    assign bus.write          = ctrl_q.write;
    assign bus.ok             = ctrl_q.ok;
    assign bus.enable         = ctrl_q.enable;
    assign bus.ALUop          = 1'b0;
    assign bus.fbeq           = 1'b0;
    assign bus.fb3j           = 1'b0;
    assign bus.steps          = steps;
`ifdef ENCODER_CTRL_WDOG_EN
    assign bus.err            = err_q;
`endif

    // Datapath contract: next-i never needs more than FIX_MAX additions of 5.
    logic [1:0] fix_run_q, fix_run_d;

    always_comb begin
        fix_run_d = '0;
        if (state_q == StFix) begin
            fix_run_d = (fix_run_q == 2'd3) ? fix_run_q : fix_run_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fix_run_q <= '0;
        end else begin
            fix_run_q <= fix_run_d;
        end
    end

    fix_bound_a: assert property (@(posedge clk) disable iff (!rst)
        !((state_q == StFix) && (fix_run_q == 2'(FIX_MAX))));

endmodule
